// File: rtl/mdu_pkg.sv
// mdu_pkg: opcode encodings, FSM state type and opcode decode helpers
// shared by the sequential multiply/divide unit.
package mdu_pkg;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic is_div(input logic [2:0] f);
    return f[2];
  endfunction

  function automatic logic is_rem(input logic [2:0] f);
    return (f == F_REM) || (f == F_REMU);
  endfunction

  // rs1 is treated as two's complement for these opcodes
  function automatic logic a_is_signed(input logic [2:0] f);
    return (f == F_MULH) || (f == F_MULHSU) || (f == F_DIV) || (f == F_REM);
  endfunction

  function automatic logic b_is_signed(input logic [2:0] f);
    return (f == F_MULH) || (f == F_DIV) || (f == F_REM);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational restoring-divide step; shifts the next
// dividend bit into the partial remainder and trial-subtracts the divisor.
module mdu_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic            dividend_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // rem_in < divisor, so a borrow shows up in diff[XLEN]
  always_comb begin
    shifted = {rem_in, dividend_bit};
    diff    = shifted - {1'b0, divisor};
    q_bit   = ~diff[XLEN];
    rem_out = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: iterative RISC-V M-extension multiply/divide unit, one bit per cycle.
// Define MDU_DIV_EN to build the divider; without it divide opcodes report illegal_op.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      fun3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            div_by_zero,
  output logic            illegal_op
);

  localparam int CW = $clog2(XLEN + 1);

  state_t          state;
  logic [2:0]      op;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] b_mag;
  logic            neg_res;
  logic [CW-1:0]   count;

  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag_in;
  logic [XLEN-1:0] b_mag_in;
  logic            neg_res_in;

  // Operands enter the datapath as magnitudes; the result sign is kept aside.
  always_comb begin
    a_neg      = a_is_signed(fun3) & op_a[XLEN-1];
    b_neg      = b_is_signed(fun3) & op_b[XLEN-1];
    a_mag_in   = a_neg ? -op_a : op_a;
    b_mag_in   = b_neg ? -op_b : op_b;
    neg_res_in = is_rem(fun3) ? a_neg : (a_neg ^ b_neg);
  end

`ifdef MDU_DIV_EN
  logic            b_zero;
  logic            div_ovf;
  logic [XLEN-1:0] div_rem;
  logic            div_qbit;

  always_comb begin
    b_zero  = (op_b == '0);
    div_ovf = ((fun3 == F_DIV) || (fun3 == F_REM)) &&
              (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (&op_b);
  end

  mdu_div_step #(
    .XLEN(XLEN)
  ) u_div_step (
    .rem_in      (hi),
    .dividend_bit(lo[XLEN-1]),
    .divisor     (b_mag),
    .rem_out     (div_rem),
    .q_bit       (div_qbit)
  );
`endif

  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] step_hi;
  logic [XLEN-1:0] step_lo;

  // hi/lo hold accumulator:multiplier for multiply, remainder:dividend-quotient for divide
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, b_mag} : '0);
    step_hi = mul_sum[XLEN:1];
    step_lo = {mul_sum[0], lo[XLEN-1:1]};
`ifdef MDU_DIV_EN
    if (is_div(op)) begin
      step_hi = div_rem;
      step_lo = {lo[XLEN-2:0], div_qbit};
    end
`endif
  end

  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_c;
  logic [XLEN-1:0]   final_res;

  // Sign correction applied to the outcome of the last step so DONE sees the final value
  always_comb begin
    prod      = {step_hi, step_lo};
    prod_c    = neg_res ? -prod : prod;
    final_res = (op == F_MUL) ? prod_c[XLEN-1:0] : prod_c[2*XLEN-1:XLEN];
`ifdef MDU_DIV_EN
    if (is_div(op)) begin
      if (is_rem(op))
        final_res = neg_res ? -step_hi : step_hi;
      else
        final_res = neg_res ? -step_lo : step_lo;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
      count       <= '0;
      op          <= F_MUL;
      hi          <= '0;
      lo          <= '0;
      b_mag       <= '0;
      neg_res     <= 1'b0;
    end else if (flush) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      count     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            op          <= fun3;
            b_mag       <= b_mag_in;
            neg_res     <= neg_res_in;
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
            in_ready    <= 1'b0;
            hi          <= '0;
            lo          <= a_mag_in;
            if (is_div(fun3)) begin
`ifdef MDU_DIV_EN
              // Zero divisor and signed overflow have fixed answers and skip CALC
              if (b_zero) begin
                state       <= S_DONE;
                out_valid   <= 1'b1;
                div_by_zero <= 1'b1;
                result      <= is_rem(fun3) ? op_a : '1;
              end else if (div_ovf) begin
                state     <= S_DONE;
                out_valid <= 1'b1;
                result    <= is_rem(fun3) ? '0 : op_a;
              end else begin
                state <= S_CALC;
                count <= CW'(XLEN);
              end
`else
              state      <= S_DONE;
              out_valid  <= 1'b1;
              illegal_op <= 1'b1;
              result     <= '0;
`endif
            end else begin
              state <= S_CALC;
              count <= CW'(XLEN);
            end
          end
        end
        S_CALC: begin
          hi    <= step_hi;
          lo    <= step_lo;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            result    <= final_res;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: self-checking bench for mdu_seq (XLEN=32) against an arithmetic
// reference model; divide expectations follow whether MDU_DIV_EN is defined.
module tb_mdu_seq;
  import mdu_pkg::*;

  localparam int XLEN = 32;
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fun3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        div_by_zero;
  logic        illegal_op;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mdu_seq #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .fun3       (fun3),
    .op_a       (op_a),
    .op_b       (op_b),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .div_by_zero(div_by_zero),
    .illegal_op (illegal_op)
  );

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  // Reference model: plain 64-bit / integer arithmetic on the RISC-V definitions
  function automatic logic [31:0] model_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int si, sj;
    logic [31:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    si = a;
    sj = b;
    r = '0;
    case (f)
      F_MUL:    begin p = ua * ub; r = p[31:0];  end
      F_MULH:   begin p = sa * sb; r = p[63:32]; end
      F_MULHSU: begin p = sa * ub; r = p[63:32]; end
      F_MULHU:  begin p = ua * ub; r = p[63:32]; end
      F_DIV:    r = (b == 0) ? 32'hFFFF_FFFF : (a == MINV && b == 32'hFFFF_FFFF) ? a : 32'(si / sj);
      F_DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      F_REM:    r = (b == 0) ? a : (a == MINV && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(si % sj);
      default:  r = (b == 0) ? a : a % b;
    endcase
    if (f[2] && !DIV_EN) r = '0;
    return r;
  endfunction

  function automatic int model_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return XLEN + 1;
    if (!DIV_EN) return 1;
    if (b == 0) return 1;
    if ((f == F_DIV || f == F_REM) && a == MINV && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return MINV;
      3: return 32'($urandom_range(1, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op at a negedge, wait (bounded) for out_valid, capture outputs, then consume.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic dbz, output logic ill, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    fun3 = f;
    op_a = a;
    op_b = b;
    @(negedge clk);
    in_valid = 1'b0;
    fun3 = 3'($urandom);
    op_a = $urandom;
    op_b = $urandom;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = result;
    dbz = div_by_zero;
    ill = illegal_op;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
    tests_run++; if (result !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_result got=%h exp=0", result); end
    tests_run++; if (div_by_zero !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_dbz got=%b exp=0", div_by_zero); end
    tests_run++; if (illegal_op !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_illegal got=%b exp=0", illegal_op); end
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        dbz;
    logic        ill;
    int          lat;
  } vec_t;

  task automatic test_mul_directed();
    vec_t tbl[4];
    logic [31:0] res;
    logic dbz, ill;
    int lat;
    tbl[0] = '{F_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b0, 33};
    tbl[1] = '{F_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 1'b0, 33};
    tbl[2] = '{F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, 33};
    tbl[3] = '{F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 33};
    for (int i = 0; i < 4; i++) begin
      do_op(tbl[i].f, tbl[i].a, tbl[i].b, res, dbz, ill, lat);
      tests_run++; if (res !== tbl[i].r) begin tests_failed++; $display("[TB] FAIL mul_dir_result idx=%0d got=%h exp=%h", i, res, tbl[i].r); end
      tests_run++; if (lat != tbl[i].lat) begin tests_failed++; $display("[TB] FAIL mul_dir_latency idx=%0d got=%0d exp=%0d", i, lat, tbl[i].lat); end
    end
  endtask

  task automatic test_div_directed();
    vec_t tbl[6];
    logic [31:0] res;
    logic dbz, ill;
    int lat;
`ifdef MDU_DIV_EN
    tbl[0] = '{F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 1};
    tbl[1] = '{F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1};
    tbl[2] = '{F_DIVU, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1};
    tbl[3] = '{F_REM,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 1'b0, 33};
    tbl[4] = '{F_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, 1'b0, 33};
    tbl[5] = '{F_REMU, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 1'b0, 1'b0, 33};
`else
    tbl[0] = '{F_DIV,  32'h0000_000A, 32'h0000_0003, 32'h0, 1'b0, 1'b1, 1};
    tbl[1] = '{F_DIVU, 32'h0000_0005, 32'h0000_0000, 32'h0, 1'b0, 1'b1, 1};
    tbl[2] = '{F_REM,  32'hFFFF_FFF9, 32'h0000_0002, 32'h0, 1'b0, 1'b1, 1};
    tbl[3] = '{F_REMU, 32'h0000_0064, 32'h0000_0000, 32'h0, 1'b0, 1'b1, 1};
    tbl[4] = '{F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 1};
    tbl[5] = '{F_DIVU, 32'hFFFF_FFFF, 32'h0000_0007, 32'h0, 1'b0, 1'b1, 1};
`endif
    for (int i = 0; i < 6; i++) begin
      do_op(tbl[i].f, tbl[i].a, tbl[i].b, res, dbz, ill, lat);
      tests_run++; if (res !== tbl[i].r) begin tests_failed++; $display("[TB] FAIL div_dir_result idx=%0d got=%h exp=%h", i, res, tbl[i].r); end
      tests_run++; if (dbz !== tbl[i].dbz) begin tests_failed++; $display("[TB] FAIL div_dir_dbz idx=%0d got=%b exp=%b", i, dbz, tbl[i].dbz); end
      tests_run++; if (ill !== tbl[i].ill) begin tests_failed++; $display("[TB] FAIL div_dir_illegal idx=%0d got=%b exp=%b", i, ill, tbl[i].ill); end
      tests_run++; if (lat != tbl[i].lat) begin tests_failed++; $display("[TB] FAIL div_dir_latency idx=%0d got=%0d exp=%0d", i, lat, tbl[i].lat); end
    end
  endtask

  task automatic test_random();
    logic [2:0] f;
    logic [31:0] a, b, res, exp_r;
    logic dbz, ill, exp_dbz, exp_ill;
    int lat, exp_lat;
    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      exp_r   = model_result(f, a, b);
      exp_lat = model_latency(f, a, b);
      exp_dbz = DIV_EN && f[2] && (b == 0);
      exp_ill = !DIV_EN && f[2];
      do_op(f, a, b, res, dbz, ill, lat);
      tests_run++; if (res !== exp_r) begin tests_failed++; $display("[TB] FAIL rand_result f=%0d a=%h b=%h got=%h exp=%h", f, a, b, res, exp_r); end
      tests_run++; if (dbz !== exp_dbz) begin tests_failed++; $display("[TB] FAIL rand_dbz f=%0d a=%h b=%h got=%b exp=%b", f, a, b, dbz, exp_dbz); end
      tests_run++; if (ill !== exp_ill) begin tests_failed++; $display("[TB] FAIL rand_illegal f=%0d got=%b exp=%b", f, ill, exp_ill); end
      tests_run++; if (lat != exp_lat) begin tests_failed++; $display("[TB] FAIL rand_latency f=%0d a=%h b=%h got=%0d exp=%0d", f, a, b, lat, exp_lat); end
    end
  endtask

  // Result must hold under back-pressure; a competing request during CALC/DONE is ignored.
  task automatic test_backpressure();
    logic [31:0] a, b, exp_r;
    int waited;
    a = $urandom;
    b = $urandom;
    exp_r = model_result(F_MULH, a, b);
    @(negedge clk);
    in_valid = 1'b1; fun3 = F_MULH; op_a = a; op_b = b;
    @(negedge clk);
    fun3 = F_MUL; op_a = $urandom; op_b = $urandom;
    waited = 0;
    while (out_valid !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_wait got=%b exp=1", out_valid); end
    for (int c = 0; c < 5; c++) begin
      tests_run++; if (result !== exp_r) begin tests_failed++; $display("[TB] FAIL bp_result cyc=%0d got=%h exp=%h", c, result, exp_r); end
      tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_in_ready cyc=%0d got=%b exp=0", c, in_ready); end
      tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_out_valid cyc=%0d got=%b exp=1", c, out_valid); end
      if (c < 4) @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_release_valid got=%b exp=0", out_valid); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_release_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_flush();
    int seen;
    @(negedge clk);
    in_valid = 1'b1;
    fun3 = DIV_EN ? F_DIVU : F_MUL;
    op_a = $urandom;
    op_b = $urandom | 32'h1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_out_valid got=%b exp=0", out_valid); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL flush_in_ready got=%b exp=1", in_ready); end
    seen = 0;
    repeat (40) begin @(negedge clk); if (out_valid === 1'b1) seen++; end
    tests_run++; if (seen != 0) begin tests_failed++; $display("[TB] FAIL flush_no_result got=%0d valid cycles exp=0", seen); end
    // flush beats a simultaneous accept
    in_valid = 1'b1; fun3 = F_MUL; op_a = 32'd3; op_b = 32'd4; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL flush_accept_ready got=%b exp=1", in_ready); end
    seen = 0;
    repeat (40) begin @(negedge clk); if (out_valid === 1'b1) seen++; end
    tests_run++; if (seen != 0) begin tests_failed++; $display("[TB] FAIL flush_accept_no_result got=%0d exp=0", seen); end
    // flush beats out_ready while in DONE
    in_valid = 1'b1; fun3 = F_MUL; op_a = 32'd6; op_b = 32'd7;
    @(negedge clk);
    in_valid = 1'b0;
    seen = 0;
    while (out_valid !== 1'b1 && seen < 100) begin @(negedge clk); seen++; end
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_done_valid got=%b exp=0", out_valid); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL flush_done_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    logic dbz, ill;
    int lat, seen;
    do_op(F_DIVU, 32'h1234_5678, 32'h0, res, dbz, ill, lat);
    @(negedge clk);
    in_valid = 1'b1; fun3 = F_MUL; op_a = 32'h0001_2345; op_b = 32'h0000_1000;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_mid_in_ready got=%b exp=1", in_ready); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_out_valid got=%b exp=0", out_valid); end
    tests_run++; if (result !== 32'h0) begin tests_failed++; $display("[TB] FAIL rst_mid_result got=%h exp=0", result); end
    tests_run++; if (div_by_zero !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_dbz got=%b exp=0", div_by_zero); end
    tests_run++; if (illegal_op !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_illegal got=%b exp=0", illegal_op); end
    seen = 0;
    repeat (40) begin @(negedge clk); if (out_valid === 1'b1) seen++; end
    tests_run++; if (seen != 0) begin tests_failed++; $display("[TB] FAIL rst_mid_discard got=%0d exp=0", seen); end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    fun3 = 3'b000;
    op_a = '0;
    op_b = '0;
    flush = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_mul_directed();
    test_div_directed();
    test_random();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired run=%0d failed=%0d", tests_run, tests_failed);
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (legal values 8..64, even).
REQ-002 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have in_valid  input  1  operation request.
REQ-005 SHALL have in_ready  output  1  unit can accept; high only in IDLE.
REQ-006 SHALL have fun3  input  3  M-extension op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have op_a  input  XLEN  rs1 value (multiplicand/dividend).
REQ-008 SHALL have op_b  input  XLEN  rs2 value (multiplier/divisor).
REQ-009 SHALL have flush  input  1  abort any in-flight op.
REQ-010 SHALL have out_valid  output  1  result available.
REQ-011 SHALL have out_ready  input  1  consumer takes result.
REQ-012 SHALL have result  output  XLEN  operation result.
REQ-013 SHALL have div_by_zero  output  1  qualified by out_valid; op was DIV/DIVU/REM/REMU with op_b==0.
REQ-014 SHALL have illegal_op  output  1  qualified by out_valid; op not supported in this build.

Function
REQ-015 SHALL implement states IDLE, CALC, DONE; accept = in_valid & in_ready & !flush, sampled in cycle N.
REQ-016 On accept SHALL latch fun3 and operands, convert signed operands to magnitude, load iteration counter with XLEN, enter CALC.
REQ-017 In CALC SHALL perform one shift-add (multiply) or one restoring subtract-shift (divide) step per cycle; CALC occupies cycles N+1..N+XLEN.
REQ-018 SHALL enter DONE with out_valid=1 in cycle N+XLEN+1 and apply sign correction so that the registered result is final in that cycle.
REQ-019 MUL SHALL return product bits [XLEN-1:0]; MULH/MULHSU/MULHU SHALL return bits [2*XLEN-1:XLEN] with signed×signed, signed×unsigned, unsigned×unsigned interpretation respectively.
REQ-020 DIV/REM SHALL round quotient toward zero; remainder sign SHALL equal dividend sign.
REQ-021 Divide by zero SHALL bypass CALC: DONE in cycle N+1, quotient all-ones, remainder op_a, div_by_zero=1.
REQ-022 Signed overflow (op_a = -2^(XLEN-1), op_b = -1) SHALL bypass CALC: DONE in cycle N+1, DIV result op_a, REM result 0.
REQ-023 In DONE, result/div_by_zero/illegal_op SHALL hold stable until out_valid & out_ready, then return to IDLE next edge; no accept in the same cycle.
REQ-024 flush SHALL, in any state, force IDLE on the next edge with out_valid=0; flush wins over simultaneous accept or out_ready.
REQ-025 in_valid while not in IDLE SHALL be ignored (requester holds).

Reset
REQ-026 reset SHALL force IDLE on next edge: in_ready=1, out_valid=0, result=0, div_by_zero=0, illegal_op=0, counter=0.
REQ-027 reset SHALL take priority over flush and accept; reset mid-CALC SHALL discard the operation.

Configuration
REQ-028 Macro MDU_DIV_EN present: divider datapath and fun3 100..111 fully supported.
REQ-029 Macro MDU_DIV_EN absent: no divider logic; fun3 100..111 SHALL complete in cycle N+1 with result=0, illegal_op=1, div_by_zero=0.

Structure
REQ-030 Package mdu_pkg SHALL hold the fun3 encoding constants and the state type.
REQ-031 Sub-module mdu_div_step SHALL implement one combinational restoring-divide step (partial remainder, quotient bit), instantiated only under MDU_DIV_EN.

Verification (XLEN=32)
REQ-032 MUL 7 × 0xFFFFFFFD accepted cycle N -> out_valid cycle N+33, result 0xFFFFFFEB.
REQ-033 MULH 0x80000000 × 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-034 DIV 0x80000000 / 0xFFFFFFFF -> result 0x80000000 at N+1; REM same operands -> 0; DIVU 5/0 -> 0xFFFFFFFF, div_by_zero=1; REM -7/2 -> 0xFFFFFFFF.
REQ-035 out_ready low 5 cycles after out_valid -> result stable all 5 cycles, in_ready low; out_ready high -> IDLE next cycle.
REQ-036 flush at cycle N+10 of a DIVU -> IDLE at N+11, out_valid never asserted; reset at N+5 -> all REQ-026 values next cycle.
REQ-037 Build without MDU_DIV_EN: DIV 10/3 -> out_valid at N+1, result 0, illegal_op=1.
